fp_dma_panel: RTL and testbench
===============================

Name: fp_dma_panel

Overview:
- Front-panel memory access controller for the Altair core, parametrised successor to the jam-instruction examine/deposit latches.
- Performs EXAMINE, EXAMINE NEXT, DEPOSIT and DEPOSIT NEXT as bus-master DMA cycles using the CPU HOLD/HLDA handshake; no opcodes are injected into the CPU.
- Sits between the debounced panel pushbuttons/switches and the memory bus mux.
- Drives the address/data LEDs from its own registers.

Parameters:
- ADDR_W, 16: address width of bus and switches.
- DATA_W, 8: data width.
- RD_LAT, 1: cycles bus_rd is held; bus_din sampled on the last one (1..15).
- HOLD_TO, 255: clk cycles allowed in REQ waiting for hlda before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pause  in  1  1 = CPU stopped; commands accepted only when 1.
- cmd_examine  in  1  one-cycle pulse.
- cmd_examine_next  in  1  one-cycle pulse.
- cmd_deposit  in  1  one-cycle pulse.
- cmd_deposit_next  in  1  one-cycle pulse.
- sw_addr  in  ADDR_W  address switches.
- sw_data  in  DATA_W  data switches.
- hold_req  out  1  bus request to CPU.
- hlda  in  1  CPU hold acknowledge.
- bus_addr  out  ADDR_W  DMA address.
- bus_dout  out  DATA_W  DMA write data.
- bus_din  in  DATA_W  memory read data.
- bus_rd  out  1  read strobe.
- bus_we  out  1  write strobe.
- cur_addr  out  ADDR_W  panel address register (address LEDs).
- disp_data  out  DATA_W  last read data (data LEDs).
- busy  out  1  operation in progress.
- err  out  1  sticky hold-timeout flag.

Behaviour:
- Reset, clk and reset: reset is synchronous, active-high; clock is clk. Reset overrides everything, including mid-operation.
- Reset values: state IDLE; cur_addr, disp_data, bus_addr, bus_dout = 0; hold_req, bus_rd, bus_we, busy, err = 0.
- States: IDLE, REQ, WR, RD, REL.

IDLE:
- A command is accepted when pause=1 and any cmd pulse is high.
- Priority when pulses coincide: deposit_next > deposit > examine_next > examine. Lower-priority pulses in the same cycle are dropped.
- Target address on accept:
  - examine: sw_addr.
  - examine_next and deposit_next: cur_addr+1, modulo 2^ADDR_W (wraps).
  - deposit: cur_addr.
- sw_data is latched on accept; err clears on accept.
- Next cycle: state REQ, busy=1, hold_req=1.
- When pause=0, all cmd pulses are ignored.
- Any cmd pulse outside IDLE is ignored; nothing is queued.

REQ:
- Hold counter starts at 0 and increments each cycle.
- hlda sampled 1: go to WR for deposits, RD for examines.
- Counter reaches HOLD_TO with hlda=0: abort.
  - hold_req=0, err=1, cur_addr and disp_data unchanged.
  - Go to REL.

WR (exactly 1 cycle):
- bus_addr=target, bus_dout=latched data, bus_we=1.
- Then go to RD, giving read-back verify.

RD (RD_LAT cycles):
- bus_addr=target, bus_rd=1.
- On the last RD cycle, bus_din is registered into disp_data and target into cur_addr, both visible the next cycle.
- hold_req drops on that same next cycle; state goes to REL.

REL:
- hold_req=0, bus_rd=0, bus_we=0, bus_addr=0.
- Stay until hlda sampled 0, then IDLE with busy=0.

Other rules:
- pause going 0 mid-operation does not abort; the operation completes.
- bus_addr and bus_dout are 0 outside WR/RD.
- bus_rd and bus_we are never high together.
- Latency with hlda rising 1 cycle after hold_req, RD_LAT=1:
  - examine: pulse at T0, hold_req T1–T3, bus_rd T3, disp_data valid T4.
  - deposit adds one WR cycle before the read.

Test Plan:
1. Examine read: sw_addr=0x1234, memory[0x1234]=0xA5, hlda echoes hold_req 1 cycle late, cmd_examine -> one bus_rd cycle at 0x1234, no bus_we, cur_addr=0x1234, disp_data=0xA5, busy low after hlda falls.
2. Examine-next wrap: cur_addr=0xFFFF, cmd_examine_next -> bus_addr=0x0000, cur_addr=0x0000.
3. Deposit then deposit-next: cur_addr=0x0100, sw_data=0x3C, cmd_deposit -> write 0x3C@0x0100, readback disp_data=0x3C. Then sw_data=0x7E, cmd_deposit_next -> write 0x7E@0x0101, cur_addr=0x0101.
4. Priority, busy and pause gating:
   - cmd_examine and cmd_deposit in the same cycle -> deposit only.
   - cmd_examine while busy -> ignored, no second hold_req.
   - pause=0 with cmd_examine -> hold_req stays 0.
5. Hold timeout: HOLD_TO=8, hlda tied 0, cmd_examine -> hold_req high 8 cycles then low, err=1, cur_addr and disp_data unchanged. A following cmd_examine with a working hlda clears err.
6. Reset mid-operation: reset asserted during RD with RD_LAT=4 -> next cycle all outputs at reset values. After release, state IDLE and commands are accepted again.

Source files
------------

// File: rtl/fp_dma_panel.sv
// fp_dma_panel: front-panel examine/deposit controller performing DMA cycles via HOLD/HLDA.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   pause                 CPU stopped; panel commands accepted only while high
//   cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next   one-cycle command pulses
//   sw_addr, sw_data      panel address/data switches
//   hold_req, hlda        bus request to CPU and its acknowledge
//   bus_addr, bus_dout, bus_din, bus_rd, bus_we   DMA memory bus
//   cur_addr, disp_data   panel address register and last read data (LEDs)
//   busy, err             operation in progress, sticky hold-timeout flag
module fp_dma_panel #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int HOLD_TO = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              cmd_examine,
    input  logic              cmd_examine_next,
    input  logic              cmd_deposit,
    input  logic              cmd_deposit_next,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_data,
    output logic              hold_req,
    input  logic              hlda,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    output logic              bus_rd,
    output logic              bus_we,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic              err
);
    localparam int HC_W = $clog2(HOLD_TO + 1);

    typedef enum logic [2:0] {IDLE, REQ, WR, RD, REL} state_t;

    state_t            state, state_nx;
    logic [HC_W-1:0]   hold_cnt;
    logic [3:0]        rd_cnt;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] wdata;
    logic              is_wr;
    logic              accept;
    logic              last_rd;
    logic              timeout;

    assign accept  = state == IDLE && pause &&
                     (cmd_examine | cmd_examine_next | cmd_deposit | cmd_deposit_next);
    assign last_rd = rd_cnt == 4'(RD_LAT - 1);
    // Abort after exactly HOLD_TO request cycles; an hlda seen on the last one still wins.
    assign timeout = hold_cnt == HC_W'(HOLD_TO - 1) && !hlda;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rd_cnt    <= '0;
            target    <= '0;
            wdata     <= '0;
            is_wr     <= 1'b0;
            cur_addr  <= '0;
            disp_data <= '0;
            err       <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= state == REQ ? hold_cnt + 1'b1 : '0;
            rd_cnt   <= state == RD ? rd_cnt + 1'b1 : '0;
            if (accept) begin
                err   <= 1'b0;
                wdata <= sw_data;
                is_wr <= cmd_deposit_next | cmd_deposit;
                // deposit_next > deposit > examine_next > examine
                target <= (cmd_deposit_next | (!cmd_deposit & cmd_examine_next)) ? cur_addr + 1'b1 :
                          cmd_deposit ? cur_addr : sw_addr;
            end
            if (state == REQ && timeout)
                err <= 1'b1;
            if (state == RD && last_rd) begin
                disp_data <= bus_din;
                cur_addr  <= target;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? REQ : IDLE;
            REQ:     state_nx = hlda ? (is_wr ? WR : RD) : (timeout ? REL : REQ);
            WR:      state_nx = RD;
            RD:      state_nx = last_rd ? REL : RD;
            REL:     state_nx = hlda ? REL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign hold_req = state == REQ || state == WR || state == RD;
    assign bus_we   = state == WR;
    assign bus_rd   = state == RD;
    assign bus_addr = (state == WR || state == RD) ? target : '0;
    assign bus_dout = state == WR ? wdata : '0;
    assign busy     = state != IDLE;

endmodule

// File: tb/tb_fp_dma_panel.sv
// tb_fp_dma_panel: scoreboard bench for fp_dma_panel with a memory model and hlda responder.
module tb_fp_dma_panel;
    localparam int RD_LAT  = 4;
    localparam int HOLD_TO = 8;

    logic        clk, reset, pause;
    logic        cmd_examine, cmd_examine_next, cmd_deposit, cmd_deposit_next;
    logic [15:0] sw_addr, bus_addr, cur_addr;
    logic [7:0]  sw_data, bus_dout, bus_din, disp_data;
    logic        hold_req, hlda, bus_rd, bus_we, busy, err;
    logic        hlda_ok;

    fp_dma_panel #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT), .HOLD_TO(HOLD_TO)) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .cmd_examine(cmd_examine), .cmd_examine_next(cmd_examine_next),
        .cmd_deposit(cmd_deposit), .cmd_deposit_next(cmd_deposit_next),
        .sw_addr(sw_addr), .sw_data(sw_data), .hold_req(hold_req), .hlda(hlda),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_rd(bus_rd), .bus_we(bus_we), .cur_addr(cur_addr), .disp_data(disp_data),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];
    assign bus_din = mem[bus_addr];
    always @(posedge clk) if (bus_we) mem[bus_addr] = bus_dout;
    // CPU grants the bus one cycle after the request and releases one cycle after it drops.
    always @(posedge clk) hlda <= hlda_ok & hold_req;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [15:0] cur;
        logic [7:0]  disp;
        logic        err;
        int          holdc;
        int          rdc;
        int          wec;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    logic [15:0] m_cur = 0;
    logic [7:0]  m_disp = 0;
    logic        m_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: checks bus cycles against the head expectation, retires it when busy falls.
    int   hc = 0, rdc = 0, wec = 0;
    logic prev_busy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_busy = 0; hc = 0; rdc = 0; wec = 0;
        end else begin
            if (bus_rd || bus_we) chk("rd_we_exclusive", 32'(bus_rd & bus_we), 0);
            if (busy && !bus_rd && !bus_we) chk("addr_zero_off_bus", 32'(bus_addr), 0);
            if (hold_req) hc++;
            if (bus_we) begin
                wec++;
                if (q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("wr_addr", 32'(bus_addr), 32'(q[0].addr));
                    chk("wr_data", 32'(bus_dout), 32'(q[0].wdata));
                end
            end
            if (bus_rd) begin
                rdc++;
                if (q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("rd_addr", 32'(bus_addr), 32'(q[0].addr));
            end
            if (prev_busy && !busy) begin
                if (q.size() == 0) chk("extra_op", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("cur_addr", 32'(cur_addr), 32'(e.cur));
                    chk("disp_data", 32'(disp_data), 32'(e.disp));
                    chk("err", 32'(err), 32'(e.err));
                    chk("hold_cycles", hc, e.holdc);
                    chk("rd_cycles", rdc, e.rdc);
                    chk("wr_cycles", wec, e.wec);
                end
                hc = 0; rdc = 0; wec = 0;
            end
            prev_busy = busy;
        end
    end

    // Issue one cycle of command pulses; when it should be accepted, predict its outcome.
    task automatic do_cmd(input logic dn, input logic d, input logic en, input logic e,
                          input logic [15:0] a, input logic [7:0] dat, input logic p);
        exp_t x;
        logic wr;
        logic [15:0] tgt;
        sw_addr = a; sw_data = dat; pause = p;
        cmd_deposit_next = dn; cmd_deposit = d; cmd_examine_next = en; cmd_examine = e;
        if (p && (dn || d || en || e)) begin
            if (dn)      begin wr = 1; tgt = m_cur + 16'd1; end
            else if (d)  begin wr = 1; tgt = m_cur; end
            else if (en) begin wr = 0; tgt = m_cur + 16'd1; end
            else         begin wr = 0; tgt = a; end
            x.addr = tgt; x.wdata = dat;
            if (hlda_ok) begin
                if (wr) ref_mem[tgt] = dat;
                m_cur = tgt; m_disp = ref_mem[tgt]; m_err = 0;
                x.holdc = 2 + (wr ? 1 : 0) + RD_LAT; x.rdc = RD_LAT; x.wec = wr ? 1 : 0;
            end else begin
                m_err = 1;
                x.holdc = HOLD_TO; x.rdc = 0; x.wec = 0;
            end
            x.cur = m_cur; x.disp = m_disp; x.err = m_err;
            q.push_back(x);
        end
        @(posedge clk); #1;
        cmd_deposit_next = 0; cmd_deposit = 0; cmd_examine_next = 0; cmd_examine = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(posedge clk); #1; n++; end
        if (busy) chk("idle_timeout", 1, 0);
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'((i * 37) ^ (i >> 8));
            ref_mem[i] = mem[i];
        end
        mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        reset = 1; pause = 1; hlda_ok = 1; sw_addr = 0; sw_data = 0;
        cmd_examine = 0; cmd_examine_next = 0; cmd_deposit = 0; cmd_deposit_next = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({hold_req, bus_rd, bus_we, busy, err}), 0);
        chk("rst_cur_addr", 32'(cur_addr), 0);
        chk("rst_disp_data", 32'(disp_data), 0);
        reset = 0;
        @(posedge clk); #1;

        // examine
        do_cmd(0, 0, 0, 1, 16'h1234, 8'h00, 1);
        wait_idle();
        // examine-next wrap
        do_cmd(0, 0, 0, 1, 16'hFFFF, 8'h00, 1);
        wait_idle();
        do_cmd(0, 0, 1, 0, 16'h5555, 8'h00, 1);
        wait_idle();
        chk("wrap_cur_addr", 32'(cur_addr), 0);
        // deposit then deposit-next
        do_cmd(0, 0, 0, 1, 16'h0100, 8'h00, 1);
        wait_idle();
        do_cmd(0, 1, 0, 0, 16'h0000, 8'h3C, 1);
        wait_idle();
        do_cmd(1, 0, 0, 0, 16'h0000, 8'h7E, 1);
        wait_idle();
        chk("mem_0100", 32'(mem[16'h0100]), 32'h3C);
        chk("mem_0101", 32'(mem[16'h0101]), 32'h7E);
        // coincident pulses: deposit wins
        do_cmd(0, 1, 0, 1, 16'h0200, 8'h99, 1);
        wait_idle();
        // command while busy is dropped
        do_cmd(0, 0, 0, 1, 16'h0300, 8'h00, 1);
        repeat (3) @(posedge clk);
        #1;
        cmd_examine = 1; sw_addr = 16'h0400;
        @(posedge clk); #1;
        cmd_examine = 0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("busy_cmd_dropped", 32'({hold_req, busy}), 0);
        // pause gating
        do_cmd(0, 0, 0, 1, 16'h0500, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pause_gate", 32'({hold_req, busy}), 0);
        pause = 1;
        // hold timeout, then recovery clears err
        hlda_ok = 0;
        do_cmd(0, 0, 0, 1, 16'h0600, 8'h00, 1);
        wait_idle();
        chk("err_sticky", 32'(err), 1);
        hlda_ok = 1;
        do_cmd(0, 0, 0, 1, 16'h0700, 8'h00, 1);
        wait_idle();
        // reset in the middle of RD
        do_cmd(0, 0, 0, 1, 16'h4321, 8'h00, 1);
        n = 0;
        while (!bus_rd && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus_rd) chk("reach_rd", 0, 1);
        @(posedge clk); #1;
        reset = 1;
        q.delete();
        m_cur = 0; m_disp = 0; m_err = 0;
        @(posedge clk); #1;
        chk("midrst_ctrl", 32'({hold_req, bus_rd, bus_we, busy, err}), 0);
        chk("midrst_bus", 32'({bus_addr, bus_dout}), 0);
        chk("midrst_regs", 32'({cur_addr, disp_data}), 0);
        @(posedge clk); #1;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        do_cmd(0, 0, 0, 1, 16'h0042, 8'h00, 1);
        wait_idle();

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            logic       p;
            c = 4'($urandom_range(1, 15));
            p = $urandom_range(0, 7) != 0;
            hlda_ok = $urandom_range(0, 5) != 0;
            do_cmd(c[3], c[2], c[1], c[0], 16'($urandom), 8'($urandom), p);
            if ($urandom_range(0, 3) == 0) pause = 0;
            if (p) wait_idle();
            else begin
                repeat (2) @(posedge clk);
                #1;
                chk("rand_pause_gate", 32'(hold_req), 0);
            end
        end
        hlda_ok = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
